// File: rtl/led_mode_ctrl_if.sv
// Pin-side signals of the LED mode controller: key/pause inputs and the LED-bank outputs.
// The controller uses the slave modport; the board/bench side uses the master modport.
interface led_mode_ctrl_if #(
    parameter int unsigned LED_NUM = 4
);
    logic               key_n;
    logic               pause;
    logic [1:0]         mode;
    logic               tick;
    logic [LED_NUM-1:0] led_sig;

    modport master (
        output key_n,
        output pause,
        input  mode,
        input  tick,
        input  led_sig
    );

    modport slave (
        input  key_n,
        input  pause,
        output mode,
        output tick,
        output led_sig
    );
endinterface

// File: rtl/led_mode_ctrl.sv
// Mode-selectable LED sequencer: tick divider, debounced mode key, pause, and four patterns.
// LEDs are active-low; a press reloads INIT_STA and restarts the divider.
module led_mode_ctrl #(
    parameter int unsigned        CLK_DIV  = 2499999,
    parameter int unsigned        LED_NUM  = 4,
    parameter logic [LED_NUM-1:0] INIT_STA = 4'b1110,
    parameter int unsigned        DEB_CNT  = 249999,
    parameter int unsigned        CNT_W    = 24
) (
    input logic            clk,
    input logic            rst,
    led_mode_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ModeShr   = 2'd0,
        ModeShl   = 2'd1,
        ModeBlink = 2'd2,
        ModePp    = 2'd3
    } mode_e;

    localparam logic [CNT_W-1:0] DivMax = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] DebMax = CNT_W'(DEB_CNT);

    logic               r_s1;
    logic               r_s2;
    logic               r_deb;
    logic [CNT_W-1:0]   r_deb_cnt;
    logic [CNT_W-1:0]   r_div_cnt;
    logic               r_dir;
    mode_e              r_mode;
    logic [LED_NUM-1:0] r_led;
    logic               r_tick;

    logic               w_deb_d;
    logic [CNT_W-1:0]   w_deb_cnt_d;
    logic [CNT_W-1:0]   w_div_cnt_d;
    logic               w_dir_d;
    mode_e              w_mode_d;
    logic [LED_NUM-1:0] w_led_d;
    logic               w_press;
    logic               w_wrap;
    logic               w_strobe;
    logic [LED_NUM-1:0] w_rot_r;
    logic [LED_NUM-1:0] w_rot_l;

    always_comb begin
        w_deb_d     = r_deb;
        w_deb_cnt_d = '0;
        w_div_cnt_d = r_div_cnt;
        w_dir_d     = r_dir;
        w_mode_d    = r_mode;
        w_led_d     = r_led;
        w_rot_r     = {r_led[0], r_led[LED_NUM-1:1]};
        w_rot_l     = {r_led[LED_NUM-2:0], r_led[LED_NUM-1]};

        // Any agreement between the synchronized key and deb restarts the stable-time count.
        if (r_s2 != r_deb) begin
            if (r_deb_cnt == DebMax) begin
                w_deb_d = r_s2;
            end else begin
                w_deb_cnt_d = r_deb_cnt + CNT_W'(1);
            end
        end

        w_press  = r_deb & ~w_deb_d;
        w_wrap   = ~bus.pause && (r_div_cnt == DivMax);
        w_strobe = w_wrap & ~w_press;

        if (w_press) begin
            w_div_cnt_d = '0;
        end else if (!bus.pause) begin
            w_div_cnt_d = w_wrap ? '0 : r_div_cnt + CNT_W'(1);
        end

        // A press on the same edge as a strobe wins: reload, no update, no tick.
        if (w_press) begin
            w_mode_d = mode_e'(r_mode + 2'd1);
            w_led_d  = INIT_STA;
            w_dir_d  = 1'b0;
        end else if (w_strobe) begin
            unique case (r_mode)
                ModeShr:   w_led_d = w_rot_r;
                ModeShl:   w_led_d = w_rot_l;
                ModeBlink: w_led_d = ~r_led;
                ModePp: begin
                    w_led_d = r_dir ? w_rot_r : w_rot_l;
                    if (!w_led_d[LED_NUM-1]) begin
                        w_dir_d = 1'b1;
                    end else if (!w_led_d[0]) begin
                        w_dir_d = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1      <= 1'b1;
            r_s2      <= 1'b1;
            r_deb     <= 1'b1;
            r_deb_cnt <= '0;
            r_div_cnt <= '0;
            r_dir     <= 1'b0;
            r_mode    <= ModeShr;
            r_led     <= INIT_STA;
            r_tick    <= 1'b0;
        end else begin
            r_s1      <= bus.key_n;
            r_s2      <= r_s1;
            r_deb     <= w_deb_d;
            r_deb_cnt <= w_deb_cnt_d;
            r_div_cnt <= w_div_cnt_d;
            r_dir     <= w_dir_d;
            r_mode    <= w_mode_d;
            r_led     <= w_led_d;
            r_tick    <= w_strobe;
        end
    end

    assign bus.mode    = r_mode;
    assign bus.tick    = r_tick;
    assign bus.led_sig = r_led;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl with CLK_DIV=3, DEB_CNT=3, LED_NUM=4.
// Expected {mode, led_sig} for each tick is queued up front; a monitor pops on every tick.
module tb_led_mode_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    led_mode_ctrl_if #(.LED_NUM(4)) bus ();

    led_mode_ctrl #(
        .CLK_DIV (3),
        .LED_NUM (4),
        .INIT_STA(4'b1110),
        .DEB_CNT (3),
        .CNT_W   (24)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    logic [5:0] exp_q[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [1:0] m, input logic [3:0] l);
        exp_q.push_back({m, l});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every tick pulse must match the next queued pattern.
    initial begin
        logic [5:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.tick === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_tick: got mode=%0d led=%b, expected no tick",
                             bus.mode, bus.led_sig);
                end else begin
                    e = exp_q.pop_front();
                    chk("tick_pattern", {2'b00, bus.mode, bus.led_sig}, {2'b00, e});
                end
            end
        end
    end

    initial begin
        rst       = 1'b0;
        bus.key_n = 1'b1;
        bus.pause = 1'b0;
        cyc(2);
        chk("reset_mode", {6'd0, bus.mode}, 8'd0);
        chk("reset_led", {4'd0, bus.led_sig}, 8'b0000_1110);
        chk("reset_tick", {7'd0, bus.tick}, 8'd0);

        // SHR after reset: strobes at R4, R8, R12, R16
        push(2'd0, 4'b0111);
        push(2'd0, 4'b1011);
        push(2'd0, 4'b1101);
        push(2'd0, 4'b1110);
        rst = 1'b1;
        cyc(16);

        // Press 1: E0=R17, mode change at R22; strobe at R20 precedes it
        push(2'd0, 4'b0111);
        push(2'd1, 4'b1101);
        push(2'd1, 4'b1011);
        bus.key_n = 1'b0;
        cyc(5);
        chk("press_latency_before", {6'd0, bus.mode}, 8'd0);
        cyc(1);
        chk("press_latency_mode", {6'd0, bus.mode}, 8'd1);
        chk("press_reload", {4'd0, bus.led_sig}, 8'b0000_1110);
        cyc(4);
        bus.key_n = 1'b1;
        cyc(4);

        // Press 2 lands on the same edge as a strobe (R38): press wins, no tick
        push(2'd1, 4'b0111);
        cyc(2);
        bus.key_n = 1'b0;
        cyc(6);
        chk("collide_mode", {6'd0, bus.mode}, 8'd2);
        chk("collide_led", {4'd0, bus.led_sig}, 8'b0000_1110);
        chk("collide_tick", {7'd0, bus.tick}, 8'd0);
        push(2'd2, 4'b0001);
        push(2'd2, 4'b1110);
        push(2'd2, 4'b0001);
        bus.key_n = 1'b1;
        cyc(12);

        // Press 3 -> PP; ping-pong bounces off both ends
        push(2'd2, 4'b1110);
        push(2'd3, 4'b1101);
        push(2'd3, 4'b1011);
        push(2'd3, 4'b0111);
        push(2'd3, 4'b1011);
        push(2'd3, 4'b1101);
        push(2'd3, 4'b1110);
        push(2'd3, 4'b1101);
        bus.key_n = 1'b0;
        cyc(6);
        chk("pp_mode", {6'd0, bus.mode}, 8'd3);
        bus.key_n = 1'b1;
        cyc(28);

        // Bouncing key never stays low long enough to register
        push(2'd3, 4'b1011);
        push(2'd3, 4'b0111);
        push(2'd3, 4'b1011);
        push(2'd3, 4'b1101);
        push(2'd3, 4'b1110);
        for (int i = 0; i < 5; i++) begin
            bus.key_n = 1'b0;
            cyc(3);
            bus.key_n = 1'b1;
            cyc(1);
        end
        chk("bounce_mode", {6'd0, bus.mode}, 8'd3);

        // Pause with divider at 2: frozen, then one more count to the next strobe
        cyc(2);
        bus.pause = 1'b1;
        cyc(20);
        chk("pause_led_frozen", {4'd0, bus.led_sig}, 8'b0000_1110);
        chk("pause_tick", {7'd0, bus.tick}, 8'd0);
        push(2'd3, 4'b1101);
        bus.pause = 1'b0;
        cyc(1);
        chk("unpause_remaining", {4'd0, bus.led_sig}, 8'b0000_1110);
        cyc(1);
        chk("unpause_update", {4'd0, bus.led_sig}, 8'b0000_1101);

        // Press during pause: wraps 3->0, reloads, divider held at 0
        bus.pause = 1'b1;
        bus.key_n = 1'b0;
        cyc(6);
        chk("pause_press_mode", {6'd0, bus.mode}, 8'd0);
        chk("pause_press_led", {4'd0, bus.led_sig}, 8'b0000_1110);
        bus.key_n = 1'b1;
        cyc(6);
        chk("pause_press_hold", {4'd0, bus.led_sig}, 8'b0000_1110);
        push(2'd0, 4'b0111);
        bus.pause = 1'b0;
        cyc(3);
        chk("unpause_full_count", {4'd0, bus.led_sig}, 8'b0000_1110);
        cyc(1);
        chk("unpause_first_update", {4'd0, bus.led_sig}, 8'b0000_0111);

        // Reset on the very edge the debounced press would have fired
        push(2'd0, 4'b1011);
        bus.key_n = 1'b0;
        cyc(5);
        rst       = 1'b0;
        bus.key_n = 1'b1;
        cyc(2);
        chk("midrst_mode", {6'd0, bus.mode}, 8'd0);
        chk("midrst_led", {4'd0, bus.led_sig}, 8'b0000_1110);
        chk("midrst_tick", {7'd0, bus.tick}, 8'd0);
        push(2'd0, 4'b0111);
        push(2'd0, 4'b1011);
        rst = 1'b1;
        cyc(8);
        chk("no_residual_press", {6'd0, bus.mode}, 8'd0);
        chk("post_rst_led", {4'd0, bus.led_sig}, 8'b0000_1011);
        cyc(2);
        chk("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_mode_ctrl.md
Name: led_mode_ctrl

Overview:
- Sequencing controller for the 4-LED board bank: owns the tick divider and selects among four display patterns.
- A debounced push-button (active-low) cycles the mode.
- A pause input freezes the pattern.
- Sits between the board key/switch pins and the LED pins; replaces a fixed single-pattern driver with a mode-selectable one.

Parameters:
- CLK_DIV, 2499999, tick period minus 1 in clk cycles (100 ms at 25 MHz).
- LED_NUM, 4, number of LEDs (>=3).
- INIT_STA, 4'b1110, LED pattern loaded at reset and on every mode change (LED_NUM bits, active-low LEDs, exactly one zero).
- DEB_CNT, 249999, debounce stable-time minus 1 in clk cycles (10 ms at 25 MHz).
- CNT_W, 24, width of the tick and debounce counters; must hold max(CLK_DIV, DEB_CNT).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- key_n  in  1  raw push-button, active-low, asynchronous to clk, bouncy.
- pause  in  1  level; 1 = hold the pattern and the tick counter.
- mode  out  2  current mode: 0 SHR, 1 SHL, 2 BLINK, 3 PP.
- tick  out  1  one-cycle pulse, high for the cycle after each pattern update.
- led_sig  out  LED_NUM  LED drive pattern.

Behaviour:
- Reset (rst==0 sampled at posedge), all registers load together:
  - mode=0, led_sig=INIT_STA, tick=0.
  - tick counter=0, debounce counter=0, dir=0.
  - Both synchronizer flops=1, debounced key=1.
- key_n passes through a 2-flop synchronizer (s1, s2).
- Debounce:
  - If s2 != deb: counter increments; when counter==DEB_CNT, deb<=s2 and counter<=0.
  - If s2==deb: counter<=0. Any bounce back restarts the count.
- Press event: the edge where deb goes 1->0 (only this direction). Released keys generate no event.
- Latency: with key_n first sampled low at edge E0 and held low, mode changes at edge E0+DEB_CNT+2.
- Tick divider:
  - pause==0: counter counts 0..CLK_DIV. At CLK_DIV it wraps to 0 and an update strobe fires on that edge.
  - pause==1: counter holds and no strobe fires.
- Pattern update on strobe, by mode:
  - SHR: led_sig <= {led_sig[0], led_sig[LED_NUM-1:1]}.
  - SHL: led_sig <= {led_sig[LED_NUM-2:0], led_sig[LED_NUM-1]}.
  - BLINK: led_sig <= ~led_sig.
  - PP (ping-pong):
    - dir==0 rotates left; dir==1 rotates right.
    - dir<=1 when the new value has bit LED_NUM-1 zero.
    - dir<=0 when the new value has bit 0 zero.
    - Period is 2*LED_NUM-2 strobes.
- tick is registered: high exactly one cycle after each strobe edge.
- Mode change (press event):
  - mode <= (mode+1) mod 4, wrapping 3->0.
  - Same edge: led_sig<=INIT_STA, tick counter<=0, dir<=0.
  - If a press and a strobe coincide, the press wins: no pattern update and no tick.
- Press during pause: mode advances and pattern reloads; the divider stays held at 0 until pause drops.
- Reset mid-count or mid-debounce: all state is discarded, with no residual press event after reset.

Test Plan (CLK_DIV=3, DEB_CNT=3, LED_NUM=4):
1. Reset: rst=0 for 2 cycles, then release, key_n=1, pause=0 -> mode=0, led_sig=1110. Strobes every 4 cycles give 0111, 1011, 1101, 1110, each followed by one tick pulse.
2. Mode cycle: press key_n=0 held for 10 cycles, first sampled at E0 -> mode=1 at E0+5 and led_sig=1110. Subsequent updates are 1101, 1011. Three more clean presses give modes 2, 3, 0 (wrap).
3. Debounce: key_n toggles low for 3 cycles, high for 1, repeated 5 times -> mode unchanged, no reload. A release after a valid press gives no second event.
4. BLINK/PP: in mode 2, updates alternate 0001/1110. In mode 3, sequence is 1110, 1101, 1011, 0111, 1011, 1101, 1110, 1101 (dir flips at both ends).
5. Pause: pause=1 mid-count for 20 cycles -> led_sig and the counter are frozen, tick=0. After pause=0, the first update occurs after the remaining count. A press during pause advances mode and reloads INIT_STA.
6. Collision/reset: align the press edge with the strobe edge -> mode advances, led_sig=1110, no tick. Assert rst=0 mid-debounce -> mode=0 and no press event after release.
